// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// State encoding, parameter defaults and the counter-width helper live here.
package pll_lock_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        FILTER,
        HOLDOFF,
        RUN
    } pll_sup_state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PLL_RST_CYCLES = 8;
    localparam int DEF_LOCK_FILTER    = 16;
    localparam int DEF_HOLDOFF        = 1024;
    localparam int DEF_RETRY_TIMEOUT  = 65536;

    localparam int RELOCK_W = 8;

    // Counter only ever reaches (terminal - 1), so clog2 of the largest terminal is enough.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Generic N-stage asynchronous-reset flop synchronizer for a single bit.
// All stages reset to 0; q is the last stage.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset and system reset release from the asynchronous PLL lock flag.
// Optional macro PLL_LOCK_SUP_RELOCK_CNT_EN implements the saturating relock counter.
module pll_lock_supervisor
    import pll_lock_sup_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int HOLDOFF        = DEF_HOLDOFF,
    parameter int RETRY_TIMEOUT  = DEF_RETRY_TIMEOUT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                sys_rst_n,
    output logic                status_locked,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_FILTER, HOLDOFF, RETRY_TIMEOUT);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST   = CNT_W'(RETRY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF - 1);

    pll_sup_state_t   state;
    pll_sup_state_t   state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lock_s;
    logic             pll_rst_d;
    logic             sys_rst_n_d;
    logic             status_locked_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Outputs are registered alongside the state so they change on the transition edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= PLL_RESET;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            status_locked <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pll_rst       <= pll_rst_d;
            sys_rst_n     <= sys_rst_n_d;
            status_locked <= status_locked_d;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        unique case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                   state_next = FILTER;
                else if (cnt == RETRY_LAST)   state_next = PLL_RESET;
            end
            FILTER: begin
                if (!lock_s)                  state_next = WAIT_LOCK;
                else if (cnt == FILTER_LAST)  state_next = pll_lock_sup_pkg::HOLDOFF;
            end
            pll_lock_sup_pkg::HOLDOFF: begin
                if (!lock_s)                  state_next = PLL_RESET;
                else if (cnt == HOLDOFF_LAST) state_next = RUN;
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) state_next = PLL_RESET;
            end
            default: begin
                state_next = PLL_RESET;
            end
        endcase
        if (state_next != state) cnt_next = '0;
    end

    always_comb begin
        pll_rst_d       = (state_next == PLL_RESET);
        sys_rst_n_d     = (state_next == RUN);
        status_locked_d = (state_next == RUN);
    end

`ifdef PLL_LOCK_SUP_RELOCK_CNT_EN
    logic relock_event;

    // Only a loss from RUN counts; a loss during hold-off is a failed attempt, not a relock.
    assign relock_event = (state == RUN) && (state_next == PLL_RESET);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            relock_count <= '0;
        end else if (relock_event && (relock_count != '1)) begin
            relock_count <= relock_count + 1'b1;
        end
    end
`else
    assign relock_count = '0;
`endif

endmodule
